// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial two's-complement adder/subtractor.
// One full-adder cell and a carry flop process the operands LSB first, one
// bit per clock. Operands arrive over a valid/ready handshake. The result,
// carry-out and signed overflow leave over a second valid/ready handshake.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow
);

  // A counter of at least one bit keeps WIDTH=1 legal.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] result_r;
  logic [CNT_W-1:0] cnt_r;
  logic             carry_r;
  logic             c_out_r;
  logic             overflow_r;
  logic             in_ready_r;
  logic             out_valid_r;

  logic [WIDTH-1:0] a_next_s;
  logic [WIDTH-1:0] b_next_s;
  logic [WIDTH-1:0] result_next_s;
  logic             sum_s;
  logic             carry_s;

  // The single full-adder cell, returned as {carry, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {((x & y) | (x & ci) | (y & ci)), (x ^ y ^ ci)};
  endfunction

  // Bit-slice datapath: add the current LSBs and form the shifted registers.
  always_comb begin
    {carry_s, sum_s} = full_add(a_sh_r[0], b_sh_r[0], carry_r);
    a_next_s         = a_sh_r >> 1'b1;
    b_next_s         = b_sh_r >> 1'b1;
    result_next_s    = result_r >> 1'b1;
    result_next_s[WIDTH-1] = sum_s;
  end

  // Control FSM with the operand, result and handshake registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      a_sh_r      <= '0;
      b_sh_r      <= '0;
      result_r    <= '0;
      cnt_r       <= '0;
      carry_r     <= 1'b0;
      c_out_r     <= 1'b0;
      overflow_r  <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          if (in_valid && in_ready_r) begin
            // Subtraction is A + ~B + 1: invert B here, seed the carry with 1.
            a_sh_r     <= a;
            b_sh_r     <= sub ? ~b : b;
            carry_r    <= sub;
            cnt_r      <= '0;
            in_ready_r <= 1'b0;
            state_r    <= SHIFT;
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          a_sh_r   <= a_next_s;
          b_sh_r   <= b_next_s;
          result_r <= result_next_s;
          carry_r  <= carry_s;
          cnt_r    <= cnt_r + CNT_W'(1);
          if (cnt_r == LAST_BIT) begin
            // carry_r here is the carry into the MSB.
            c_out_r     <= carry_s;
            overflow_r  <= carry_r ^ carry_s;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            state_r <= SHIFT;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign c_out     = c_out_r;
  assign overflow  = overflow_r;

endmodule
